// File: rtl/energy_arb_pkg.sv
// Shared types and constants for the energy counter arbiter.
// State encoding and request direction values used by energy_arbiter and rr_picker.
package energy_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_COOL  = 2'd2
  } arb_state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage : energy_arb_pkg

// File: rtl/energy_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
// Returns the winner index and a valid flag when any requester is eligible.
module rr_picker
  import energy_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  localparam logic [IW:0] NREQ_W = N_REQ[IW:0];

  logic [IW:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = {1'b0, ptr} + off[IW:0];
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (elig[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/energy_arbiter.sv
// Round-robin arbiter serialising requests into single inc/dec pulses for the energy counter.
// Optional saturation filter enabled by defining ENERGY_ARB_SAT_FILTER_EN.
//
// state     | meaning
// ARB_IDLE  | waiting for an eligible request; arbitration happens on this edge
// ARB_GRANT | one-cycle grant and counter pulse to the latched winner
// ARB_COOL  | enforced gap of GAP cycles before the next arbitration
module energy_arbiter
  import energy_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 7,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_dir,
  input  logic             asleep,
  input  logic [W-1:0]     energy,
  output logic [N_REQ-1:0] gnt,
  output logic             en_inc,
  output logic             en_dec,
  output logic             dropped,
  output logic             busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IW:0]      NREQ_W   = N_REQ[IW:0];
  localparam logic [CW-1:0]    GAP_W    = GAP[CW-1:0];
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] elig;
  logic [IW-1:0]    pick_win;
  logic             pick_valid;
  logic             dir_now;
  logic             sat_hit;
  logic [IW:0]      ptr_inc;
  logic [IW-1:0]    ptr_nxt;

  logic [N_REQ-1:0] gnt_d;
  logic             en_inc_d;
  logic             en_dec_d;
  logic             dropped_d;
  logic             busy_d;

  // Requester 0 (sleep controller) is the only one allowed through while asleep.
  assign elig = req & {{(N_REQ-1){~asleep}}, 1'b1};

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .elig   (elig),
    .ptr    (ptr_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  assign dir_now = req_dir[pick_win];

`ifdef ENERGY_ARB_SAT_FILTER_EN
  assign sat_hit = (dir_now == DIR_INC) ? (energy == {W{1'b1}}) : (energy == {W{1'b0}});
`else
  logic unused_energy;
  assign unused_energy = ^energy;
  assign sat_hit       = 1'b0;
`endif

  assign ptr_inc = {1'b0, win_q} + {{IW{1'b0}}, 1'b1};
  assign ptr_nxt = (ptr_inc == NREQ_W) ? '0 : ptr_inc[IW-1:0];

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    en_inc_d  = 1'b0;
    en_dec_d  = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d   = ARB_GRANT;
          gnt_d     = GNT_ONE << pick_win;
          en_inc_d  = (dir_now == DIR_INC) && !sat_hit;
          en_dec_d  = (dir_now == DIR_DEC) && !sat_hit;
          dropped_d = sat_hit;
        end
      end
      ARB_GRANT: begin
        state_d = (GAP > 0) ? ARB_COOL : ARB_IDLE;
      end
      ARB_COOL: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      en_inc  <= 1'b0;
      en_dec  <= 1'b0;
      dropped <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      en_inc  <= en_inc_d;
      en_dec  <= en_dec_d;
      dropped <= dropped_d;
      busy    <= busy_d;
      if (state_q == ARB_IDLE && pick_valid) begin
        win_q <= pick_win;
      end
      if (state_q == ARB_GRANT) begin
        ptr_q <= ptr_nxt;
        cnt_q <= GAP_W;
      end else if (state_q == ARB_COOL && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

endmodule : energy_arbiter

// File: tb/tb_energy_arbiter.sv
// Directed self-checking bench for energy_arbiter (N_REQ=4, W=7, GAP=1).
// Observed vector is {gnt[3:0], en_inc, en_dec, dropped, busy}, sampled 1 ns after posedge.
module tb_energy_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_dir;
  logic       asleep;
  logic [6:0] energy;
  logic [3:0] gnt;
  logic       en_inc;
  logic       en_dec;
  logic       dropped;
  logic       busy;
  logic [7:0] obs;

  int vec_count;
  int miss_count;

  energy_arbiter #(
    .N_REQ (4),
    .W     (7),
    .GAP   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_dir (req_dir),
    .asleep  (asleep),
    .energy  (energy),
    .gnt     (gnt),
    .en_inc  (en_inc),
    .en_dec  (en_dec),
    .dropped (dropped),
    .busy    (busy)
  );

  assign obs = {gnt, en_inc, en_dec, dropped, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_dir = 4'b0001; asleep = 1'b0; energy = 7'd10;
    tick(2);
    vec_count++;
    if (obs !== 8'b0000_0000) begin
      miss_count++;
      $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'b0000_0000);
    end
    rst = 1'b0;
    tick(1);
    vec_count++;
    if (obs !== 8'b0001_1001) begin
      miss_count++;
      $display("FAIL reset_first_grant obs=%b exp=%b", obs, 8'b0001_1001);
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_single();
    req = 4'b0100; req_dir = 4'b0100;
    tick(1);
    vec_count++;
    if (obs !== 8'b0100_1001) begin
      miss_count++;
      $display("FAIL single_grant obs=%b exp=%b", obs, 8'b0100_1001);
    end
    tick(1);
    vec_count++;
    if (obs !== 8'b0000_0001) begin
      miss_count++;
      $display("FAIL single_cool obs=%b exp=%b", obs, 8'b0000_0001);
    end
    tick(1);
    vec_count++;
    if (obs !== 8'b0000_0000) begin
      miss_count++;
      $display("FAIL single_idle obs=%b exp=%b", obs, 8'b0000_0000);
    end
    tick(1);
    vec_count++;
    if (obs !== 8'b0100_1001) begin
      miss_count++;
      $display("FAIL single_regrant obs=%b exp=%b", obs, 8'b0100_1001);
    end
    req = 4'b0000;
    tick(2);
  endtask

  // Grants at cycles 0,3,6,9,12 go to 0,1,2,3,0; COOL cycles show busy only.
  task automatic test_fairness();
    logic [7:0] exp;
    logic [3:0] dirs;
    int         w;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    dirs = 4'b1010;
    req = 4'b1111; req_dir = dirs;
    for (int i = 0; i < 13; i++) begin
      tick(1);
      if (i % 3 == 0) begin
        w = (i / 3) % 4;
        exp = {4'b0001 << w, dirs[w], ~dirs[w], 1'b0, 1'b1};
      end else if (i % 3 == 1) begin
        exp = 8'b0000_0001;
      end else begin
        exp = 8'b0000_0000;
      end
      vec_count++;
      if (obs !== exp) begin
        miss_count++;
        $display("FAIL fairness_cycle%0d obs=%b exp=%b", i, obs, exp);
      end
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_sleep_lock();
    int bad;
    asleep = 1'b1; req = 4'b1110; req_dir = 4'b0001;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (obs !== 8'b0000_0000) bad++;
    end
    vec_count++;
    if (bad != 0) begin
      miss_count++;
      $display("FAIL sleep_blocked bad_cycles=%0d exp=0", bad);
    end
    req = 4'b1111;
    tick(1);
    vec_count++;
    if (obs !== 8'b0001_1001) begin
      miss_count++;
      $display("FAIL sleep_req0 obs=%b exp=%b", obs, 8'b0001_1001);
    end
    req = 4'b1110;
    tick(2);
    asleep = 1'b0;
    tick(1);
    vec_count++;
    if (obs !== 8'b0010_0101) begin
      miss_count++;
      $display("FAIL sleep_wake_req1 obs=%b exp=%b", obs, 8'b0010_0101);
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_saturation();
    logic [7:0] exp;
    energy = 7'd127; req = 4'b0010; req_dir = 4'b0010;
`ifdef ENERGY_ARB_SAT_FILTER_EN
    exp = 8'b0010_0011;
`else
    exp = 8'b0010_1001;
`endif
    tick(1);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("FAIL sat_inc_full obs=%b exp=%b", obs, exp);
    end
    req = 4'b0000;
    tick(2);
    energy = 7'd0; req = 4'b0001; req_dir = 4'b0000;
`ifdef ENERGY_ARB_SAT_FILTER_EN
    exp = 8'b0001_0011;
`else
    exp = 8'b0001_0101;
`endif
    tick(1);
    vec_count++;
    if (obs !== exp) begin
      miss_count++;
      $display("FAIL sat_dec_empty obs=%b exp=%b", obs, exp);
    end
    req = 4'b0000;
    tick(2);
    energy = 7'd0; req = 4'b0100; req_dir = 4'b0100;
    tick(1);
    vec_count++;
    if (obs !== 8'b0100_1001) begin
      miss_count++;
      $display("FAIL sat_inc_from_zero obs=%b exp=%b", obs, 8'b0100_1001);
    end
    req = 4'b0000;
    tick(2);
    energy = 7'd10;
  endtask

  task automatic test_reset_mid();
    req = 4'b0100; req_dir = 4'b0000;
    tick(1);
    vec_count++;
    if (obs !== 8'b0100_0101) begin
      miss_count++;
      $display("FAIL midrst_pre_grant obs=%b exp=%b", obs, 8'b0100_0101);
    end
    rst = 1'b1; req = 4'b1000; req_dir = 4'b1000;
    tick(1);
    vec_count++;
    if (obs !== 8'b0000_0000) begin
      miss_count++;
      $display("FAIL midrst_cleared obs=%b exp=%b", obs, 8'b0000_0000);
    end
    rst = 1'b0;
    tick(1);
    vec_count++;
    if (obs !== 8'b1000_1001) begin
      miss_count++;
      $display("FAIL midrst_after_release obs=%b exp=%b", obs, 8'b1000_1001);
    end
    req = 4'b0000;
    tick(2);
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst = 1'b1; req = '0; req_dir = '0; asleep = 1'b0; energy = '0;
    test_reset();
    test_single();
    test_fairness();
    test_sleep_lock();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule : tb_energy_arbiter
